// File: rtl/avg_pkg.sv
// Shared types and constants for the sample-stream blocks feeding the averager.
package avg_pkg;

    localparam int AVG_DATA_W = 16;
    localparam int AVG_WIN    = 12;
    localparam int WIN_CNT_W  = 4;

    typedef logic [AVG_DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } src_state_t;

endpackage

// File: rtl/skid_reg1.sv
// One-entry holding register: load captures din, unload empties it.
// Load wins over unload so a simultaneous refill keeps the entry valid.
module skid_reg1
    import avg_pkg::*;
#(
    parameter int W = AVG_DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    // Entry storage and occupancy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/avg_stream_src.sv
// Reads a run of samples from a synchronous RAM and streams them to the
// averager, with a hold input that stalls both reads and emission.
//
// state  | meaning
// IDLE   | waiting for start; N=0 start only pulses done
// STREAM | issuing one RAM read per unheld cycle
// DRAIN  | all reads issued; emitting in-flight/skid data, then done
//
// While held, mem_rd stays low, so the RAM output register keeps the last
// word it returned. That word can therefore stay parked on mem_data while the
// skid entry holds the word that arrived at the hold edge, which is why a
// single skid entry is enough.
module avg_stream_src
    import avg_pkg::*;
#(
    parameter int DATA_W = AVG_DATA_W,
    parameter int ADDR_W = 10,
    parameter int WIN    = AVG_WIN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_samples,
    input  logic              hold,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              win_full,
    output logic              busy,
    output logic              done
);

    localparam logic [WIN_CNT_W-1:0] WIN_SAT  = WIN_CNT_W'(WIN);
    localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(WIN - 1);

    src_state_t state, state_nxt;

    logic [ADDR_W-1:0]    n_lat;
    logic [ADDR_W-1:0]    rd_cnt;
    logic [ADDR_W-1:0]    rd_cnt_inc;
    logic [ADDR_W-1:0]    em_cnt;
    logic [WIN_CNT_W-1:0] win_cnt;
    logic                 pend;
    logic                 run;
    logic                 accept;
    logic                 start_idle;
    logic                 zero_start;
    logic                 issue;
    logic                 finish;
    logic                 emit_skid;
    logic                 emit_mem;
    logic                 emit;
    logic                 skid_load;
    logic                 skid_valid;
    logic [DATA_W-1:0]    skid_dout;

    assign run        = (state != IDLE);
    assign busy       = run;
    assign start_idle = (state == IDLE) && start;
    assign rd_cnt_inc = rd_cnt + 1'b1;

    // Skid entry is drained before any parked RAM word, preserving order.
    assign emit_skid = run && !hold && skid_valid;
    assign emit_mem  = run && !hold && !skid_valid && pend;
    assign emit      = emit_skid || emit_mem;
    assign skid_load = run && hold && pend && !skid_valid;

    skid_reg1 #(.W(DATA_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .unload (emit_skid),
        .din    (mem_data),
        .dout   (skid_dout),
        .valid  (skid_valid)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        zero_start = 1'b0;
        issue      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_samples != '0) begin
                        accept    = 1'b1;
                        state_nxt = (num_samples == ADDR_W'(1)) ? DRAIN : STREAM;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (rd_cnt_inc == n_lat) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (em_cnt == n_lat) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read port, run counters and end-of-run pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            n_lat    <= '0;
            rd_cnt   <= '0;
            em_cnt   <= '0;
            pend     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done   <= zero_start || finish;
            mem_rd <= accept || issue;
            pend   <= mem_rd || (pend && !(emit_mem || skid_load));
            if (accept) begin
                mem_addr <= '0;
                n_lat    <= num_samples;
                rd_cnt   <= ADDR_W'(1);
                em_cnt   <= '0;
            end else begin
                if (issue) begin
                    mem_addr <= mem_addr + 1'b1;
                    rd_cnt   <= rd_cnt_inc;
                end
                if (emit) begin
                    em_cnt <= em_cnt + 1'b1;
                end
            end
        end
    end

    // Stream output register; holds its last value while nothing is emitted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= emit;
            if (emit_skid) begin
                sample_out <= skid_dout;
            end else if (emit_mem) begin
                sample_out <= mem_data;
            end
        end
    end

    // Window-full flag from a saturating count of emitted samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt  <= '0;
            win_full <= 1'b0;
        end else if (start_idle) begin
            win_cnt  <= '0;
            win_full <= 1'b0;
        end else if (emit && (win_cnt != WIN_SAT)) begin
            win_cnt <= win_cnt + 1'b1;
            if (win_cnt == WIN_LAST) begin
                win_full <= 1'b1;
            end
        end
    end

endmodule
